mem_wr_rd_master: RTL and testbench

MEM_WR_RD_MASTER -- requirements
Module: mem_wr_rd_master

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_pattern_gen.sv | 12 +
 rtl/mem_wr_rd_master.sv | 120 ++++++++++++
 tb/tb_mem_wr_rd_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared FSM state encoding and default geometry for the RAM write/read test master.
package mem_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/mem_pattern_gen.sv
// Test pattern for a given index: seed plus index, wrapping at the data width.
// Purely combinational, zero latency; no flow control.
module mem_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 5
) (
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [DATA_WIDTH-1:0] o_pattern
);
  assign o_pattern = i_seed + DATA_WIDTH'(i_idx);
endmodule

// File: rtl/mem_wr_rd_master.sv
// Writes seed+i patterns to a RAM window, reads them back and counts mismatches.
// Done arrives 2*count+2 cycles after start (1 cycle for count==0); start ignored while busy.
module mem_wr_rd_master
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  localparam int CW = ADDR_WIDTH + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic                  r_cmp_vld;
  logic [CW-1:0]         r_err_cnt;
  logic [ADDR_WIDTH-1:0] r_first_err;
  logic                  r_pass;

  logic [DATA_WIDTH-1:0] w_pattern;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_mismatch;
  logic [CW-1:0]         w_err_nxt;

  mem_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (CW)
  ) u_pattern_gen (
    .i_seed    (r_seed),
    .i_idx     (r_idx),
    .o_pattern (w_pattern)
  );

  assign w_last     = (r_idx == r_count - CW'(1));
  assign w_accept   = (r_state == IDLE) && start;
  assign w_mismatch = r_cmp_vld && (rdata != r_exp);
  assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + CW'(1) : r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (count == '0) ? DONE : WRITE;
      WRITE:   if (w_last) w_state_nxt = READ;
      READ:    if (w_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data lags rd_en by one cycle, so the expected pattern and address ride one stage behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_count     <= '0;
      r_base      <= '0;
      r_seed      <= '0;
      r_exp       <= '0;
      r_cmp_addr  <= '0;
      r_cmp_vld   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_cmp_vld  <= (r_state == READ);
      r_cmp_addr <= addr;
      r_exp      <= w_pattern;
      if (w_accept) begin
        r_base      <= base_addr;
        r_count     <= count;
        r_seed      <= seed;
        r_idx       <= '0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
      end else begin
        r_err_cnt <= w_err_nxt;
        if (w_mismatch && (r_err_cnt == '0)) r_first_err <= r_cmp_addr;
        if ((r_state == WRITE) || (r_state == READ)) r_idx <= w_last ? '0 : r_idx + CW'(1);
      end
      if (w_state_nxt == DONE) r_pass <= (r_state == IDLE) ? 1'b1 : (w_err_nxt == '0);
    end
  end

  assign addr           = r_base + r_idx[ADDR_WIDTH-1:0];
  assign wdata          = w_pattern;
  assign wr_en          = (r_state == WRITE);
  assign rd_en          = (r_state == READ);
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
endmodule

// File: tb/tb_mem_wr_rd_master.sv
// Scoreboarded bench: stimulus queues expected RAM bus events and done results; a monitor checks them.
module tb_mem_wr_rd_master;
  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic [7:0] seed;
  logic [3:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_addr;

  mem_wr_rd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .count          (count),
    .seed           (seed),
    .addr           (addr),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .wdata          (wdata),
    .rdata          (rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  typedef struct {
    bit         is_wr;
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int         cyc;
    bit         pass;
    logic [4:0] err;
    logic [3:0] first;
  } done_t;

  ev_t   ev_q[$];
  done_t done_q[$];
  ev_t   mon_ev;
  done_t mon_done;
  int    vecs = 0;
  int    errs = 0;
  int    cyc  = 0;
  bit    stuck = 1'b0;
  bit    prev_pass = 1'b0;
  logic [7:0] mem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with an optional stuck-at-0 on bit 1 of address 3.
  always @(posedge clk) begin
    if (wr_en) mem[addr] <= (stuck && addr == 4'd3) ? (wdata & 8'hFD) : wdata;
    if (rd_en) rdata <= mem[addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en && rd_en) chk("wr_rd_overlap", 1, 0);
    if (wr_en || rd_en) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_bus_op", {wr_en, rd_en}, 0);
      end else begin
        mon_ev = ev_q.pop_front();
        chk("bus_is_write", wr_en, mon_ev.is_wr);
        chk("bus_cycle", cyc, mon_ev.cyc);
        chk("bus_addr", addr, mon_ev.addr);
        if (wr_en) chk("wdata", wdata, mon_ev.data);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        mon_done = done_q.pop_front();
        chk("done_cycle", cyc, mon_done.cyc);
        chk("pass", pass, mon_done.pass);
        chk("err_cnt", err_cnt, mon_done.err);
        chk("first_err_addr", first_err_addr, mon_done.first);
      end
    end
  end

  task automatic push_ops(input int s, input logic [3:0] b, input int n, input logic [7:0] sd, input int n_rd);
    ev_t e;
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      a = b + 4'(i);
      d = sd + 8'(i);
      e.is_wr = 1'b1; e.cyc = s + 1 + i; e.addr = a; e.data = d;
      ev_q.push_back(e);
    end
    for (int i = 0; i < n_rd; i++) begin
      a = b + 4'(i);
      e.is_wr = 1'b0; e.cyc = s + 1 + n + i; e.addr = a; e.data = 8'h00;
      ev_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      if (done_q.size() == 0) break;
      @(posedge clk);
    end
    if (done_q.size() != 0) begin
      chk("done_timeout", done_q.size(), 0);
      done_q.delete();
      ev_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_test(input logic [3:0] b, input int n, input logic [7:0] sd,
                          input int e_err, input int e_first, input bit e_pass, input bit dup);
    done_t d;
    int s;
    @(posedge clk); #1;
    s = cyc;
    push_ops(s, b, n, sd, n);
    d.cyc = (n == 0) ? s + 1 : s + 2 * n + 2;
    d.pass = e_pass; d.err = 5'(e_err); d.first = 4'(e_first);
    done_q.push_back(d);
    base_addr = b; count = 5'(n); seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err_cnt, 0);
    if (n != 0) chk("pass_held", pass, prev_pass);
    if (dup) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      base_addr = 4'd7; count = 5'd2; seed = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    prev_pass = e_pass;
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_addr, 0);
    reset = 1'b0;

    run_test(4'd0, 16, 8'h10, 0, 0, 1'b1, 1'b0);
    run_test(4'd14, 4, 8'hFE, 0, 0, 1'b1, 1'b0);
    stuck = 1'b1;
    run_test(4'd0, 8, 8'hFF, 1, 3, 1'b0, 1'b0);
    stuck = 1'b0;
    run_test(4'd0, 0, 8'hAA, 0, 0, 1'b1, 1'b0);
    run_test(4'd2, 6, 8'h40, 0, 0, 1'b1, 1'b1);

    // Reset during the second READ cycle: reads 0 and 1 happen, then everything stops.
    @(posedge clk); #1;
    s = cyc;
    push_ops(s, 4'd0, 4, 8'h33, 2);
    base_addr = 4'd0; count = 5'd4; seed = 8'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_ignored_in_reset", busy, 0);
    reset = 1'b0; start = 1'b0;
    prev_pass = 1'b0;
    run_test(4'd9, 16, 8'hC0, 0, 0, 1'b1, 1'b0);

    chk("bus_queue_drained", ev_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
